// File: rtl/layer0_writer.sv
// rtl/layer0_writer.sv - layer-0 result sink: ReLU write-back plus 2x2 max-pool to layer-1
//
// Purpose:
//   Consumes a 64x64 raster stream of signed 19-bit convolution results.
//   Every accepted pixel is rectified and written to layer-0 memory; the
//   rectified values are max-pooled over 2x2 windows (stride 2) and the
//   32x32 pooled map is written to layer-1 memory. o_done marks the frame end.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   i_valid    result present on i_data (always consumed, no backpressure)
//   i_data     19-bit two's complement conv result, raster order
//   o_busy     high while a frame is partially received
//   o_l0_we    layer-0 write strobe
//   o_l0_addr  layer-0 address (pixel index)
//   o_l0_data  ReLU result, zero-extended to 20 bits
//   o_l1_we    layer-1 write strobe
//   o_l1_addr  pooled address (row>>1)*32 + (col>>1)
//   o_l1_data  pooled max, zero-extended to 20 bits
//   o_done     one-cycle pulse coincident with the writes of pixel 4095

module layer0_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [18:0] i_data,
  output logic        o_busy,
  output logic        o_l0_we,
  output logic [11:0] o_l0_addr,
  output logic [19:0] o_l0_data,
  output logic        o_l1_we,
  output logic [9:0]  o_l1_addr,
  output logic [19:0] o_l1_data,
  output logic        o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [5:0]  r_col;
  logic [5:0]  r_row;
  logic [18:0] r_h;
  logic [18:0] r_lb [0:31];

  logic        r_busy;
  logic        r_done;
  logic        r_l0_we;
  logic [11:0] r_l0_addr;
  logic [19:0] r_l0_data;
  logic        r_l1_we;
  logic [9:0]  r_l1_addr;
  logic [19:0] r_l1_data;

  logic [18:0] w_relu;
  logic [18:0] w_pair_max;
  logic [18:0] w_lb_rd;
  logic [18:0] w_pool;
  logic        w_last;
  logic        w_pool_wr;

  // Negative results clamp to zero; the remaining value is non-negative, so
  // all later comparisons can be unsigned.
  assign w_relu     = i_data[18] ? 19'd0 : i_data;
  assign w_pair_max = (r_h > w_relu) ? r_h : w_relu;
  assign w_lb_rd    = r_lb[r_col[5:1]];
  assign w_pool     = (w_lb_rd > w_pair_max) ? w_lb_rd : w_pair_max;
  assign w_last     = (r_row == 6'd63) && (r_col == 6'd63);
  assign w_pool_wr  = i_valid && r_row[0] && r_col[0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_next = S_RUN;
      S_RUN:   if (i_valid && w_last) w_next = S_DONE;
      S_DONE:  w_next = i_valid ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Flags are registered from the next state so they line up with the
      // state they describe rather than trailing it by a cycle.
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Raster counters; natural 6-bit wrap gives 63->0 on both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= 6'd0;
      r_row <= 6'd0;
    end else if (i_valid) begin
      r_col <= r_col + 6'd1;
      if (r_col == 6'd63) r_row <= r_row + 6'd1;
    end
  end

  // Even column: latch the left value of the pair. Odd column on an even
  // row: park the top-pair max in the line buffer for the row below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= 19'd0;
      for (int i = 0; i < 32; i++) r_lb[i] <= 19'd0;
    end else if (i_valid) begin
      if (!r_col[0]) r_h <= w_relu;
      else if (!r_row[0]) r_lb[r_col[5:1]] <= w_pair_max;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l0_we   <= 1'b0;
      r_l0_addr <= 12'd0;
      r_l0_data <= 20'd0;
      r_l1_we   <= 1'b0;
      r_l1_addr <= 10'd0;
      r_l1_data <= 20'd0;
    end else begin
      r_l0_we <= i_valid;
      r_l1_we <= w_pool_wr;
      if (i_valid) begin
        r_l0_addr <= {r_row, r_col};
        r_l0_data <= {1'b0, w_relu};
      end
      if (w_pool_wr) begin
        r_l1_addr <= {r_row[5:1], r_col[5:1]};
        r_l1_data <= {1'b0, w_pool};
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_l0_we   = r_l0_we;
  assign o_l0_addr = r_l0_addr;
  assign o_l0_data = r_l0_data;
  assign o_l1_we   = r_l1_we;
  assign o_l1_addr = r_l1_addr;
  assign o_l1_data = r_l1_data;

endmodule

// File: tb/tb_layer0_writer.sv
// tb/tb_layer0_writer.sv - self-checking bench for layer0_writer

module tb_layer0_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [18:0] i_data;
  logic        o_busy;
  logic        o_l0_we;
  logic [11:0] o_l0_addr;
  logic [19:0] o_l0_data;
  logic        o_l1_we;
  logic [9:0]  o_l1_addr;
  logic [19:0] o_l1_data;
  logic        o_done;

  layer0_writer dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_busy    (o_busy),
    .o_l0_we   (o_l0_we),
    .o_l0_addr (o_l0_addr),
    .o_l0_data (o_l0_data),
    .o_l1_we   (o_l1_we),
    .o_l1_addr (o_l1_addr),
    .o_l1_data (o_l1_data),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] max4(input logic [18:0] a, b, c, d);
    logic [18:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Pooled value of window k when every pixel carries its own index: the
  // bottom-right pixel of the window is always the largest.
  function automatic int pool_idx(input int k);
    return (2 * (k >> 5) + 1) * 64 + 2 * (k & 31) + 1;
  endfunction

  // Reference model: remembers the rectified frame and derives each write
  // directly from the pixel index and the stored neighbours.
  logic [18:0] frame [0:4095];
  int          mp;
  int          row_m, col_m;
  logic [18:0] rv;
  logic        exp_busy, exp_done, exp_l0_we, exp_l1_we;
  logic [11:0] exp_l0_addr;
  logic [19:0] exp_l0_data, exp_l1_data;
  logic [9:0]  exp_l1_addr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mp          <= 0;
      exp_busy    <= 1'b0;
      exp_done    <= 1'b0;
      exp_l0_we   <= 1'b0;
      exp_l1_we   <= 1'b0;
      exp_l0_addr <= '0;
      exp_l0_data <= '0;
      exp_l1_addr <= '0;
      exp_l1_data <= '0;
    end else begin
      exp_l0_we <= i_valid;
      exp_l1_we <= 1'b0;
      exp_done  <= 1'b0;
      if (i_valid) begin
        rv    = i_data[18] ? 19'd0 : i_data;
        row_m = mp / 64;
        col_m = mp % 64;
        frame[mp]   <= rv;
        exp_l0_addr <= mp[11:0];
        exp_l0_data <= {1'b0, rv};
        if ((row_m % 2 == 1) && (col_m % 2 == 1)) begin
          exp_l1_we   <= 1'b1;
          exp_l1_addr <= 10'((row_m / 2) * 32 + col_m / 2);
          exp_l1_data <= {1'b0, max4(frame[mp-65], frame[mp-64], frame[mp-1], rv)};
        end
        exp_done <= (mp == 4095);
        exp_busy <= (mp != 4095);
        mp       <= (mp + 1) % 4096;
      end
    end
  end

  int l0_cnt = 0, l1_cnt = 0, done_cnt = 0;
  int l0_base = 0, l1_base = 0;
  logic idx_mode = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", o_busy, exp_busy);
      chk("done", o_done, exp_done);
      chk("l0_we", o_l0_we, exp_l0_we);
      chk("l1_we", o_l1_we, exp_l1_we);
      if (exp_l0_we) begin
        chk("l0_addr", o_l0_addr, exp_l0_addr);
        chk("l0_data", o_l0_data, exp_l0_data);
      end
      if (exp_l1_we) begin
        chk("l1_addr", o_l1_addr, exp_l1_addr);
        chk("l1_data", o_l1_data, exp_l1_data);
      end
      if (idx_mode && o_l0_we) begin
        chk("idx_l0_addr", o_l0_addr, l0_cnt - l0_base);
        chk("idx_l0_data", o_l0_data, l0_cnt - l0_base);
      end
      if (idx_mode && o_l1_we) begin
        chk("idx_l1_addr", o_l1_addr, l1_cnt - l1_base);
        chk("idx_l1_data", o_l1_data, pool_idx(l1_cnt - l1_base));
      end
      if (o_l0_we) l0_cnt++;
      if (o_l1_we) l1_cnt++;
      if (o_done)  done_cnt++;
    end
  end

  task automatic drive(input logic v, input logic [18:0] d);
    @(negedge clk);
    #1;
    i_valid = v;
    i_data  = d;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_l0_we"}, o_l0_we, 0);
    chk({tag, "_l1_we"}, o_l1_we, 0);
    chk({tag, "_l0_addr"}, o_l0_addr, 0);
    chk({tag, "_l0_data"}, o_l0_data, 0);
    chk({tag, "_l1_addr"}, o_l1_addr, 0);
    chk({tag, "_l1_data"}, o_l1_data, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    #1;
    check_outputs_zero(tag);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [18:0] d;
    int d0, d1, dn, acc;

    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("por");
    reset = 1'b0;

    // First pixel after reset, then a mid-frame reset with writes in flight.
    drive(1'b1, 19'd5);
    drive(1'b0, 19'd0);
    chk("first_we", o_l0_we, 1);
    chk("first_addr", o_l0_addr, 0);
    chk("first_data", o_l0_data, 5);
    chk("first_busy", o_busy, 1);
    for (int j = 1; j < 80; j++) begin
      rnd = $urandom();
      drive(1'b1, rnd[18:0]);
    end
    drive(1'b1, 19'd7);
    do_reset("midrst");

    // ReLU boundaries.
    drive(1'b1, 19'h7FFFF);
    drive(1'b1, 19'h3FFFF);
    chk("relu_neg1_addr", o_l0_addr, 0);
    chk("relu_neg1_data", o_l0_data, 0);
    drive(1'b0, 19'd0);
    chk("relu_max_addr", o_l0_addr, 1);
    chk("relu_max_data", o_l0_data, 20'h3FFFF);
    do_reset("rst2");

    // Pool windows 0 (3,9,12,-4) and 1 (all negative).
    for (int p = 0; p < 68; p++) begin
      case (p)
        0:  d = 19'd3;
        1:  d = 19'd9;
        2:  d = 19'h7FFFB;
        3:  d = 19'h7FFF9;
        64: d = 19'd12;
        65: d = 19'h7FFFC;
        66: d = 19'h40000;
        67: d = 19'h7FFFF;
        default: d = 19'd0;
      endcase
      drive(1'b1, d);
      if (p == 66) begin
        chk("pool0_we", o_l1_we, 1);
        chk("pool0_addr", o_l1_addr, 0);
        chk("pool0_data", o_l1_data, 12);
        chk("pool0_l0addr", o_l0_addr, 65);
      end
    end
    drive(1'b0, 19'd0);
    chk("pool1_we", o_l1_we, 1);
    chk("pool1_addr", o_l1_addr, 1);
    chk("pool1_data", o_l1_data, 0);
    do_reset("rst3");

    // Continuous index frame chained straight into a random frame.
    drive(1'b0, 19'd0);
    d0 = l0_cnt; d1 = l1_cnt; dn = done_cnt;
    l0_base = l0_cnt; l1_base = l1_cnt;
    idx_mode = 1'b1;
    for (int j = 0; j < 8192; j++) begin
      rnd = $urandom();
      d = (j < 4096) ? 19'(j) : rnd[18:0];
      drive(1'b1, d);
      if (j == 4096) begin
        idx_mode = 1'b0;
        chk("frameA_l0_count", l0_cnt - d0, 4096);
        chk("frameA_l1_count", l1_cnt - d1, 1024);
        chk("frameA_done_count", done_cnt - dn, 1);
        chk("chain_done", o_done, 1);
        chk("chain_done_busy", o_busy, 0);
        chk("chain_last_l0", o_l0_addr, 4095);
        chk("chain_last_l1", o_l1_addr, 1023);
      end
      if (j == 4097) begin
        chk("chain_p0_we", o_l0_we, 1);
        chk("chain_p0_addr", o_l0_addr, 0);
        chk("chain_p0_done", o_done, 0);
        chk("chain_p0_busy", o_busy, 1);
      end
    end
    drive(1'b0, 19'd0);
    drive(1'b0, 19'd0);
    chk("chain_done_count", done_cnt - dn, 2);
    chk("chain_idle_busy", o_busy, 0);

    // Gapped index frame at roughly 30% duty.
    do_reset("rst4");
    drive(1'b0, 19'd0);
    d0 = l0_cnt; d1 = l1_cnt; dn = done_cnt;
    l0_base = l0_cnt; l1_base = l1_cnt;
    idx_mode = 1'b1;
    acc = 0;
    while (acc < 4096) begin
      if ($urandom_range(0, 99) < 30) begin
        drive(1'b1, 19'(acc));
        acc++;
      end else begin
        drive(1'b0, 19'd0);
        if (acc >= 1) chk("gap_busy", o_busy, 1);
      end
    end
    drive(1'b0, 19'd0);
    drive(1'b0, 19'd0);
    idx_mode = 1'b0;
    chk("gap_l0_count", l0_cnt - d0, 4096);
    chk("gap_l1_count", l1_cnt - d1, 1024);
    chk("gap_done_count", done_cnt - dn, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer0_writer.md
# layer0_writer

Sink for the layer-0 convolution result stream. Takes one 19-bit signed result per valid cycle in raster order over a 64x64 frame. Applies ReLU and writes each value to the layer-0 result memory. Also computes 2x2/stride-2 max pooling on the ReLU'd values and writes the 32x32 pooled map to the layer-1 memory, then signals frame completion.

## Interface
- No parameters. Frame is fixed at 64x64 with a 2x2 pool window.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- i_valid  input  1  result present on i_data this cycle; no backpressure, every asserted cycle is consumed
- i_data  input  19  conv result, two's complement, raster order (pixel 0 = row 0 col 0, pixel 4095 = row 63 col 63)
- o_busy  output  1  high while a frame is partially received (state RUN)
- o_l0_we  output  1  layer-0 memory write strobe
- o_l0_addr  output  12  layer-0 write address = pixel index
- o_l0_data  output  20  ReLU result, bit 19 always 0
- o_l1_we  output  1  layer-1 memory write strobe
- o_l1_addr  output  10  pooled address = (row>>1)*32 + (col>>1)
- o_l1_data  output  20  pooled max, bit 19 always 0
- o_done  output  1  one-cycle pulse coincident with the writes of pixel 4095

## Operation
- Counters: col[5:0], row[5:0]. Both increment only on i_valid. col wraps 63->0 and carries into row; row wraps 63->0.
- ReLU: r = i_data[18] ? 0 : i_data. Result is 19-bit unsigned, zero-extended to 20 bits on both write ports.
- Pool datapath:
  - line buffer lb[0:31] of 19 bits holds the max of each top-row pair.
  - register h holds the even-column value.
- Pool update per accepted pixel:
  - row even, col even: h <= r.
  - row even, col odd: lb[col>>1] <= max(h, r).
  - row odd, col even: h <= r.
  - row odd, col odd: pooled = max(lb[col>>1], h, r); issue layer-1 write.
- Comparisons are unsigned on the 19-bit ReLU'd values. On ties, either operand may be chosen (the values are equal).
- State machine:
  - IDLE: o_busy=0. An i_valid is accepted as pixel 0 and moves to RUN.
  - RUN: o_busy=1. Accepting pixel 4095 moves to DONE. With i_valid low, stay in RUN; gaps of any length are legal.
  - DONE: lasts exactly one cycle, during which o_done=1. Counters are already 0 here. An i_valid in DONE is accepted as pixel 0 of the next frame and moves to RUN; otherwise the next state is IDLE.
- Layer-0 write occurs for every accepted pixel. Layer-1 write occurs only for row-odd/col-odd pixels, i.e. 1024 per frame.
- When both writes fire in the same cycle, both are issued; the two ports are independent.
- lb and h are not cleared between frames. Every entry is rewritten before it is read, so stale contents never reach o_l1_data.

## Timing
- All outputs are registered.
- Latency: an i_valid at edge t produces o_l0_we/addr/data (and o_l1_*, when applicable) valid for exactly the cycle after edge t. The strobes are high for one cycle per accepted pixel.
- o_done is asserted in the same cycle as the write strobes for pixel 4095 (the o_l1_addr=1023 write).
- o_busy rises the cycle after pixel 0 is accepted and falls in the DONE cycle.
- Back-to-back i_valid for 4096 cycles gives exactly 4096 layer-0 writes and 1024 layer-1 writes, with no gaps added by the block.
- Reset, including mid-frame, returns the block to:
  - state IDLE, row=col=0, h=0, all lb=0;
  - all outputs 0.
  A partially received frame is discarded and the next i_valid is pixel 0.
- Write addresses/data are don't-care when the matching we=0. The bench must check them only under we.

## Test plan
- Reset check: assert reset mid-operation -> all outputs 0 the same cycle. After release, first i_valid with data 5 -> o_l0_addr=0, o_l0_data=5 one cycle later; o_busy=1 from that cycle.
- ReLU: i_data=19'h7FFFF (-1) at pixel 0 -> o_l0_data=0. i_data=19'h3FFFF -> o_l0_data=20'h3FFFF.
- Pool: pixels (0,0)=3, (0,1)=9, (1,0)=12, (1,1)=-4 -> o_l1_we once, addr 0, data 12, in the same cycle as o_l0_addr=65. All-negative window -> data 0.
- Full frame with pixel value = index, continuous valid:
  - 4096 l0 writes, addr = data = index;
  - 1024 l1 writes, addr k carrying data (2*(k>>5)+1)*64 + 2*(k&31) + 1;
  - o_done once, with the addr-1023 write.
- Gapped stream: random i_valid duty of 30% over a frame -> same write contents and order as the continuous case; o_busy stays high throughout the gaps.
- Frame chaining: i_valid held high across the frame boundary -> DONE lasts one cycle, the next-frame pixel 0 is written at addr 0 in the following cycle, and o_done pulses once per frame.
